// File: rtl/pl0_stall_ctrl_pkg.sv
// Shared types and constants for the PL0 fetch-stall controller.
package pl0_stall_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STALL_W = 3;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [STALL_W-1:0] {
        PL0_STALL_NONE     = 3'd0,
        PL0_STALL_1        = 3'd1,
        PL0_STALL_1_BRANCH = 3'd2,
        PL0_STALL_1_ALU    = 3'd3,
        PL0_STALL_IMM      = 3'd4
    } pl0_stall_state;

    typedef enum logic [1:0] {
        ST_DECODE = 2'd0,
        ST_SEQ    = 2'd1,
        ST_MEM    = 2'd2
    } pl0_ctrl_state;

    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/pl0_stall_ctrl_opc.sv
// Combinational opcode classifier: stall command and follow-on action per opcode.
module pl0_opc_class
    import pl0_stall_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    output logic [STALL_W-1:0] stall_c,
    output logic               seq_c,
    output logic               mem_c,
    output logic               retire_c
);

    always_comb begin
        stall_c  = PL0_STALL_NONE;
        seq_c    = 1'b0;
        mem_c    = 1'b0;
        retire_c = 1'b0;
        case (opcode)
            OPC_BRANCH: begin
                stall_c = PL0_STALL_1_BRANCH;
                seq_c   = 1'b1;
            end
            OPC_JALR: begin
                stall_c = PL0_STALL_1_ALU;
                seq_c   = 1'b1;
            end
            OPC_JAL: begin
                stall_c  = PL0_STALL_IMM;
                retire_c = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                stall_c = PL0_STALL_1;
                mem_c   = 1'b1;
            end
            default: retire_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/pl0_stall_ctrl.sv
// PL0 fetch-stall controller: decode/sequence/memory-wait FSM with timeout.
// Optional retired-instruction counter enabled by PL0_RETIRE_CNT_EN.
module pl0_stall_ctrl
    import pl0_stall_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_mem_ready,
    output logic [STALL_W-1:0] o_stall_state,
    output logic               o_mem_req,
    output logic               o_busy,
    output logic               o_retire,
    output logic               o_err,
    output logic [DATA_W-1:0]  o_retired_cnt
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    pl0_ctrl_state      state, state_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic [STALL_W-1:0] cls_stall_c;
    logic               cls_seq_c, cls_mem_c, cls_retire_c;
    logic [STALL_W-1:0] stall_c;
    logic               mem_req_c, retire_c, err_set_c;
    logic               unused_instr_hi_c;

    assign unused_instr_hi_c = ^i_instr[INSTR_W-1:OPC_W];

    pl0_opc_class u_opc_class (
        .opcode   (i_instr[OPC_W-1:0]),
        .stall_c  (cls_stall_c),
        .seq_c    (cls_seq_c),
        .mem_c    (cls_mem_c),
        .retire_c (cls_retire_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_DECODE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // Ready is checked before timeout so a same-cycle completion still retires.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        stall_c   = PL0_STALL_NONE;
        mem_req_c = 1'b0;
        retire_c  = 1'b0;
        err_set_c = 1'b0;
        case (state)
            ST_DECODE: begin
                stall_c   = cls_stall_c;
                retire_c  = cls_retire_c;
                mem_req_c = cls_mem_c;
                if (cls_seq_c) begin
                    state_nxt = ST_SEQ;
                end
                if (cls_mem_c) begin
                    tmo_nxt   = '0;
                    state_nxt = ST_MEM;
                end
            end
            ST_SEQ: begin
                retire_c  = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_MEM: begin
                if (i_mem_ready) begin
                    retire_c  = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT)) begin
                    err_set_c = 1'b1;
                    state_nxt = ST_DECODE;
                end else begin
                    stall_c = PL0_STALL_1;
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_nxt = ST_DECODE;
        endcase
    end

    // Reset overrides the Mealy outputs in the same cycle it is asserted.
    always_comb begin
        o_stall_state = stall_c;
        o_mem_req     = mem_req_c;
        o_retire      = retire_c;
        o_busy        = (state != ST_DECODE);
        if (i_rst) begin
            o_stall_state = PL0_STALL_NONE;
            o_mem_req     = 1'b0;
            o_retire      = 1'b0;
            o_busy        = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (err_set_c) begin
            o_err <= 1'b1;
        end
    end

`ifdef PL0_RETIRE_CNT_EN
    logic [DATA_W-1:0] retired_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retired_cnt <= '0;
        end else if (retire_c) begin
            retired_cnt <= retired_cnt + DATA_W'(1);
        end
    end

    assign o_retired_cnt = retired_cnt;
`else
    assign o_retired_cnt = '0;
`endif

endmodule

// File: tb/tb_pl0_stall_ctrl.sv
// Randomized self-checking bench for pl0_stall_ctrl against an instruction-level model.
module tb_pl0_stall_ctrl;
    import pl0_stall_ctrl_pkg::*;

    localparam int unsigned TMO = 15;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_instr;
    logic        i_mem_ready;
    logic [2:0]  o_stall_state;
    logic        o_mem_req;
    logic        o_busy;
    logic        o_retire;
    logic        o_err;
    logic [31:0] o_retired_cnt;

    int n_tests;
    int n_fail;
    logic        exp_err;
    logic [31:0] exp_cnt;

    pl0_stall_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_instr       (i_instr),
        .i_mem_ready   (i_mem_ready),
        .o_stall_state (o_stall_state),
        .o_mem_req     (o_mem_req),
        .o_busy        (o_busy),
        .o_retire      (o_retire),
        .o_err         (o_err),
        .o_retired_cnt (o_retired_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] junk();
        return $urandom;
    endfunction

    // One clock cycle: drive, sample at the falling edge, advance past the rising edge.
    task automatic step(input logic [31:0] instr, input logic rdy, input logic [2:0] e_stall,
                        input logic e_req, input logic e_busy, input logic e_ret);
        i_instr     = instr;
        i_mem_ready = rdy;
        @(negedge i_clk);
        check("stall",  32'(o_stall_state), 32'(e_stall));
        check("memreq", 32'(o_mem_req),     32'(e_req));
        check("busy",   32'(o_busy),        32'(e_busy));
        check("retire", 32'(o_retire),      32'(e_ret));
        check("err",    32'(o_err),         32'(exp_err));
        check("rcnt",   o_retired_cnt,      exp_cnt);
        @(posedge i_clk);
        #1;
`ifdef PL0_RETIRE_CNT_EN
        if (e_ret) exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    // Asynchronous reset asserted mid-cycle; everything must read cleared before the next edge.
    task automatic reset_step();
        i_instr     = junk();
        i_mem_ready = 1'($urandom_range(0, 1));
        #2;
        i_rst = 1'b1;
        exp_err = 1'b0;
        exp_cnt = 32'd0;
        @(negedge i_clk);
        check("rst_stall",  32'(o_stall_state), 32'(PL0_STALL_NONE));
        check("rst_memreq", 32'(o_mem_req),     32'd0);
        check("rst_busy",   32'(o_busy),        32'd0);
        check("rst_retire", 32'(o_retire),      32'd0);
        check("rst_err",    32'(o_err),         32'd0);
        check("rst_rcnt",   o_retired_cnt,      32'd0);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    // Instruction-level model: expected cycle trace derived from the opcode class.
    // rdy_at = index of the memory-wait cycle in which ready is given (> TMO means never).
    task automatic run_instr(input logic [31:0] instr, input int rdy_at);
        logic [6:0] opc;
        opc = instr[6:0];
        if (opc == OPC_BRANCH || opc == OPC_JALR) begin
            step(instr, 1'($urandom_range(0, 1)),
                 (opc == OPC_BRANCH) ? 3'(PL0_STALL_1_BRANCH) : 3'(PL0_STALL_1_ALU), 1'b0, 1'b0, 1'b0);
            step(junk(), 1'($urandom_range(0, 1)), 3'(PL0_STALL_NONE), 1'b0, 1'b1, 1'b1);
        end else if (opc == OPC_JAL) begin
            step(instr, 1'($urandom_range(0, 1)), 3'(PL0_STALL_IMM), 1'b0, 1'b0, 1'b1);
        end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
            step(instr, 1'($urandom_range(0, 1)), 3'(PL0_STALL_1), 1'b1, 1'b0, 1'b0);
            for (int k = 0; k <= int'(TMO); k++) begin
                if (k == rdy_at) begin
                    step(junk(), 1'b1, 3'(PL0_STALL_NONE), 1'b0, 1'b1, 1'b1);
                    break;
                end else if (k == int'(TMO)) begin
                    step(junk(), 1'b0, 3'(PL0_STALL_NONE), 1'b0, 1'b1, 1'b0);
                    exp_err = 1'b1;
                end else begin
                    step(junk(), 1'b0, 3'(PL0_STALL_1), 1'b0, 1'b1, 1'b0);
                end
            end
        end else begin
            step(instr, 1'($urandom_range(0, 1)), 3'(PL0_STALL_NONE), 1'b0, 1'b0, 1'b1);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opc;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: opc = OPC_BRANCH;
            1: opc = OPC_JALR;
            2: opc = OPC_JAL;
            3: opc = OPC_LOAD;
            4: opc = OPC_STORE;
            5: opc = 7'd0;
            default: begin
                opc = 7'($urandom);
                if (opc == OPC_BRANCH || opc == OPC_JALR || opc == OPC_JAL ||
                    opc == OPC_LOAD || opc == OPC_STORE) opc = 7'b0010011;
            end
        endcase
        w[6:0] = opc;
        return w;
    endfunction

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        exp_err     = 1'b0;
        exp_cnt     = 32'd0;
        i_rst       = 1'b1;
        i_instr     = 32'd0;
        i_mem_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        reset_step();

        // Plain ALU op held for four cycles
        for (int i = 0; i < 4; i++) run_instr(32'h0000_0013, 0);
`ifdef PL0_RETIRE_CNT_EN
        check("cnt_after4", o_retired_cnt, 32'd4);
`else
        check("cnt_tied0", o_retired_cnt, 32'd0);
`endif
        run_instr(32'h0000_0063, 0);
        run_instr(32'h0000_0067, 0);
        run_instr(32'h0000_006F, 0);
        run_instr(32'h0000_0000, 0);
        run_instr(32'h0000_2003, 2);
        run_instr(32'h0000_2023, 0);
        run_instr(32'h0000_2003, int'(TMO));
        check("no_err_on_tie", 32'(o_err), 32'd0);
        run_instr(32'h0000_2023, 1000);
        check("err_after_tmo", 32'(o_err), 32'd1);
        for (int i = 0; i < 6; i++) run_instr(rand_instr(), 3);
        check("err_sticky", 32'(o_err), 32'd1);

        // Reset on the second memory-wait cycle abandons the access
        reset_step();
        step(32'h0000_2003, 1'b0, 3'(PL0_STALL_1), 1'b1, 1'b0, 1'b0);
        step(junk(), 1'b0, 3'(PL0_STALL_1), 1'b0, 1'b1, 1'b0);
        reset_step();
        run_instr(32'h0000_0013, 0);
        // Reset during the sequence cycle
        step(32'h0000_0063, 1'b0, 3'(PL0_STALL_1_BRANCH), 1'b0, 1'b0, 1'b0);
        reset_step();
        run_instr(32'h0000_006F, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) reset_step();
            run_instr(rand_instr(), int'($urandom_range(0, TMO + 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
